// File: rtl/pre_fetch_stage.sv
// pre_fetch_stage: pre-IF stage that owns the fetch PC, issues instruction SRAM requests and hands accepted PCs to IF
module pre_fetch_stage #(
    parameter logic [31:0] RESET_PC  = 32'h1c000000,
    parameter int          BR_BUS_WD = 33
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 fetch_allowin,
    input  logic [BR_BUS_WD-1:0] branch_bus,
    input  logic                 wb_ex,
    input  logic                 ertn_flush,
    input  logic [31:0]          ex_entry,
    input  logic [31:0]          ertn_entry,
    output logic                 pre_fetch_to_fetch_valid,
    output logic [32:0]          pre_fetch_to_fetch_bus,
    output logic                 inst_sram_req,
    output logic                 inst_sram_wr,
    output logic [1:0]           inst_sram_size,
    output logic [3:0]           inst_sram_wstrb,
    output logic [31:0]          inst_sram_addr,
    output logic [31:0]          inst_sram_wdata,
    input  logic                 inst_sram_addr_ok
);
    typedef enum logic {IDLE, REQ} state_e;

    state_e      state_q, state_d;
    logic [31:0] npc_q, npc_d;
    logic        rd_buf_valid_q, rd_buf_valid_d;
    logic [31:0] rd_buf_target_q, rd_buf_target_d;
    logic        out_valid_q, out_valid_d;
    logic [31:0] out_pc_q, out_pc_d;
    logic        out_discard_q, out_discard_d;

    logic        br_taken;
    logic [31:0] br_target;
    logic        redirect_now;
    logic [31:0] redirect_target;
    logic        addr_hs;
    logic        slot_drain;
    logic        slot_free;

    assign br_taken   = branch_bus[BR_BUS_WD-1];
    assign br_target  = branch_bus[31:0];
    assign addr_hs    = (state_q == REQ) & inst_sram_addr_ok;
    assign slot_drain = out_valid_q & fetch_allowin;
    assign slot_free  = ~out_valid_q | fetch_allowin;

    // Redirect arbitration: exception beats ertn beats branch
    always_comb begin
        redirect_now    = wb_ex | ertn_flush | br_taken;
        redirect_target = wb_ex      ? ex_entry   :
                          ertn_flush ? ertn_entry : br_target;
    end

    // State register plus all datapath registers
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q         <= IDLE;
            npc_q           <= RESET_PC;
            rd_buf_valid_q  <= 1'b0;
            rd_buf_target_q <= 32'h0;
            out_valid_q     <= 1'b0;
            out_pc_q        <= 32'h0;
            out_discard_q   <= 1'b0;
        end else begin
            state_q         <= state_d;
            npc_q           <= npc_d;
            rd_buf_valid_q  <= rd_buf_valid_d;
            rd_buf_target_q <= rd_buf_target_d;
            out_valid_q     <= out_valid_d;
            out_pc_q        <= out_pc_d;
            out_discard_q   <= out_discard_d;
        end
    end

    // Next state: request only when the output slot can take the result
    always_comb begin
        state_d = state_q;
        if (state_q == IDLE)
            state_d = slot_free ? REQ : IDLE;
        else
            state_d = inst_sram_addr_ok ? IDLE : REQ;
    end

    // Next PC and redirect buffer; the address is frozen while a request is pending
    always_comb begin
        npc_d           = npc_q;
        rd_buf_valid_d  = rd_buf_valid_q;
        rd_buf_target_d = rd_buf_target_q;
        if (state_q == IDLE) begin
            npc_d = redirect_now ? redirect_target : npc_q;
        end else if (inst_sram_addr_ok) begin
            npc_d          = redirect_now   ? redirect_target :
                             rd_buf_valid_q ? rd_buf_target_q : npc_q + 32'd4;
            rd_buf_valid_d = 1'b0;
        end else if (redirect_now) begin
            rd_buf_valid_d  = 1'b1;
            rd_buf_target_d = redirect_target;
        end
    end

    // Output slot: load on handshake, clear on drain, mark stale on redirect while held
    always_comb begin
        out_valid_d   = out_valid_q;
        out_pc_d      = out_pc_q;
        out_discard_d = out_discard_q;
        if (addr_hs) begin
            out_valid_d   = 1'b1;
            out_pc_d      = npc_q;
            out_discard_d = rd_buf_valid_q | redirect_now;
        end else if (slot_drain) begin
            out_valid_d = 1'b0;
        end else if (out_valid_q & redirect_now) begin
            out_discard_d = 1'b1;
        end
    end

    // Outputs decoded from state and registers
    always_comb begin
        inst_sram_req            = (state_q == REQ);
        inst_sram_wr             = 1'b0;
        inst_sram_size           = 2'b10;
        inst_sram_wstrb          = 4'h0;
        inst_sram_addr           = {npc_q[31:2], 2'b00};
        inst_sram_wdata          = 32'h0;
        pre_fetch_to_fetch_valid = out_valid_q;
        pre_fetch_to_fetch_bus   = {out_discard_q, out_pc_q};
    end
endmodule

// File: tb/tb_pre_fetch_stage.sv
// tb_pre_fetch_stage: directed self-checking bench for pre_fetch_stage
module tb_pre_fetch_stage;
    logic        clk;
    logic        reset;
    logic        fetch_allowin;
    logic [32:0] branch_bus;
    logic        wb_ex;
    logic        ertn_flush;
    logic [31:0] ex_entry;
    logic [31:0] ertn_entry;
    logic        valid_o;
    logic [32:0] bus_o;
    logic        req;
    logic        wr;
    logic [1:0]  size;
    logic [3:0]  wstrb;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        addr_ok;
    int          n_cmp;
    int          n_err;

    pre_fetch_stage dut (
        .clk(clk),
        .reset(reset),
        .fetch_allowin(fetch_allowin),
        .branch_bus(branch_bus),
        .wb_ex(wb_ex),
        .ertn_flush(ertn_flush),
        .ex_entry(ex_entry),
        .ertn_entry(ertn_entry),
        .pre_fetch_to_fetch_valid(valid_o),
        .pre_fetch_to_fetch_bus(bus_o),
        .inst_sram_req(req),
        .inst_sram_wr(wr),
        .inst_sram_size(size),
        .inst_sram_wstrb(wstrb),
        .inst_sram_addr(addr),
        .inst_sram_wdata(wdata),
        .inst_sram_addr_ok(addr_ok)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic chk_req(input string tag, input logic [31:0] a);
        chk({tag, ".req"}, 64'(req), 64'd1);
        chk({tag, ".addr"}, 64'(addr), 64'(a));
    endtask

    task automatic chk_slot(input string tag, input logic d, input logic [31:0] pc);
        chk({tag, ".valid"}, 64'(valid_o), 64'd1);
        chk({tag, ".bus"}, 64'(bus_o), 64'({d, pc}));
    endtask

    initial begin
        n_cmp         = 0;
        n_err         = 0;
        reset         = 1'b0;
        fetch_allowin = 1'b1;
        addr_ok       = 1'b1;
        branch_bus    = 33'h0;
        wb_ex         = 1'b0;
        ertn_flush    = 1'b0;
        ex_entry      = 32'h0;
        ertn_entry    = 32'h0;
        @(negedge clk);
        chk("rst.req", 64'(req), 64'd0);
        chk("rst.valid", 64'(valid_o), 64'd0);
        chk("rst.bus", 64'(bus_o), 64'd0);
        chk("rst.addr", 64'(addr), 64'h1c000000);
        chk("const", 64'({wr, size, wstrb, wdata}), 64'({1'b0, 2'b10, 4'h0, 32'h0}));
        reset = 1'b1;
        // streaming with addr_ok tied high
        step(); chk_req("s0", 32'h1c000000);
        chk("s0.valid", 64'(valid_o), 64'd0);
        step(); chk_slot("s0o", 1'b0, 32'h1c000000);
        chk("s0o.req", 64'(req), 64'd0);
        step(); chk_req("s1", 32'h1c000004);
        chk("s1.valid", 64'(valid_o), 64'd0);
        step(); chk_slot("s1o", 1'b0, 32'h1c000004);
        // stalled request with a branch in the 2nd wait cycle
        addr_ok = 1'b0;
        step(); chk_req("w1", 32'h1c000008);
        branch_bus = {1'b1, 32'h1c000100};
        step(); chk_req("w2", 32'h1c000008);
        branch_bus = 33'h0;
        step(); chk_req("w3", 32'h1c000008);
        addr_ok = 1'b1;
        step(); chk_slot("w4o", 1'b1, 32'h1c000008);
        step(); chk_req("br", 32'h1c000100);
        // IF back-pressure
        fetch_allowin = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            chk_slot("hold", 1'b0, 32'h1c000100);
            chk("hold.req", 64'(req), 64'd0);
        end
        fetch_allowin = 1'b1;
        step(); chk_req("resume", 32'h1c000104);
        chk("resume.valid", 64'(valid_o), 64'd0);
        // simultaneous redirects in IDLE: exception wins
        step(); chk_slot("pri0", 1'b0, 32'h1c000104);
        wb_ex      = 1'b1; ex_entry   = 32'h1c008000;
        ertn_flush = 1'b1; ertn_entry = 32'h1c000400;
        branch_bus = {1'b1, 32'h1c000200};
        step(); chk_req("pri", 32'h1c008000);
        wb_ex = 1'b0; ertn_flush = 1'b0; branch_bus = 33'h0;
        step(); chk_slot("prio", 1'b0, 32'h1c008000);
        // held slot discarded by ertn
        branch_bus = {1'b1, 32'h1c000010};
        step(); chk_req("h0", 32'h1c000010);
        branch_bus = 33'h0;
        fetch_allowin = 1'b0;
        step(); chk_slot("h1", 1'b0, 32'h1c000010);
        ertn_flush = 1'b1;
        step(); chk_slot("ertn", 1'b1, 32'h1c000010);
        chk("ertn.req", 64'(req), 64'd0);
        ertn_flush = 1'b0;
        fetch_allowin = 1'b1;
        step(); chk_req("ertn.next", 32'h1c000400);
        // npc wrap
        step(); chk_slot("wr0", 1'b0, 32'h1c000400);
        branch_bus = {1'b1, 32'hfffffffc};
        step(); chk_req("wr1", 32'hfffffffc);
        branch_bus = 33'h0;
        step(); chk_slot("wr2", 1'b0, 32'hfffffffc);
        step(); chk_req("wrap", 32'h00000000);
        // asynchronous reset mid-REQ
        #2 reset = 1'b0;
        #1;
        chk("arst.req", 64'(req), 64'd0);
        chk("arst.valid", 64'(valid_o), 64'd0);
        chk("arst.addr", 64'(addr), 64'h1c000000);
        @(negedge clk);
        reset = 1'b1;
        step(); chk_req("rel", 32'h1c000000);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
